// File: rtl/cpu_defs.sv
// Shared CPU-side definitions for the uncached data-bus path.
//   dbus_state_e : responder state encoding
//   wbuf_entry_t : one posted uncached store (address, data, byte lanes)
//   is_pow2      : elaboration helper for buffer-depth sanity checks
package cpu_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_REQ  = 3'd4,
        WR_DONE = 3'd5,
        DRAIN   = 3'd6
    } dbus_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uncached_wbuf.sv
// Posted-store FIFO for uncached writes.
// Ports:
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   push, push_entry  : enqueue one store
//   pop               : dequeue the head (memory accepted it)
//   head              : oldest entry, valid while !empty
//   full, empty       : occupancy flags
// A push while full is accepted when a pop happens in the same cycle: the
// slot being vacated is the one being written.
module uncached_wbuf
    import cpu_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    output wbuf_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wbuf_entry_t   store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = store[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok)
            store[wr_ptr] <= push_entry;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_uncached_responder.sv
// Uncached data-bus responder: turns CPU uncached loads/stores into a
// single-outstanding request/grant/response memory transaction.
// Build option: UNCACHED_WBUF_EN adds a posted write buffer (uncached_wbuf,
// WBUF_DEPTH entries). Without it every store is a blocking WR_REQ/WR_DONE
// round trip and WBUF_DEPTH has no effect.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   dbus_read, dbus_write               : CPU request, held while dbus_stall
//   dbus_address/wrdata/byteenable      : CPU request payload
//   dbus_stall                          : request not yet complete
//   dbus_rddata                         : load data, valid as stall falls
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                   : memory request (held until mem_gnt)
//   mem_gnt                             : memory accepted the request
//   mem_rvalid, mem_rdata               : read response
module dbus_uncached_responder
    import cpu_defs::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_address,
    input  logic [31:0] dbus_wrdata,
    input  logic [3:0]  dbus_byteenable,
    output logic        dbus_stall,
    output logic [31:0] dbus_rddata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    if (!is_pow2(WBUF_DEPTH) || WBUF_DEPTH < 2 || WBUF_DEPTH > 16) begin : g_bad_depth
        $error("WBUF_DEPTH must be a power of two in 2..16");
    end

    dbus_state_e state_q;
    dbus_state_e state_d;
    logic [31:0] rddata_q;
    logic        stall_c;
    logic        wr_pres;
    logic        rd_pres;

    // A simultaneous read+write is a write; the read is dropped.
    assign wr_pres = dbus_write;
    assign rd_pres = dbus_read & ~dbus_write;

`ifdef UNCACHED_WBUF_EN
    wbuf_entry_t wb_in;
    wbuf_entry_t wb_head;
    logic        wb_full;
    logic        wb_empty;
    logic        wb_issue;
    logic        wb_push;
    logic        wb_pop;
    logic        wb_hold_q;

    assign wb_in.addr = dbus_address;
    assign wb_in.data = dbus_wrdata;
    assign wb_in.be   = dbus_byteenable;

    // Background drain runs in IDLE while no read is presented. A buffer
    // request already on the bus but not yet granted is kept up even if a
    // read shows up, so mem_req never drops before mem_gnt.
    assign wb_issue = ~wb_empty &
                      (((state_q == IDLE) & (~rd_pres | wb_hold_q)) |
                       (state_q == DRAIN));
    assign wb_pop   = wb_issue & mem_gnt;
    assign wb_push  = (state_q == IDLE) & wr_pres & (~wb_full | wb_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_hold_q <= 1'b0;
        else
            wb_hold_q <= wb_issue & ~mem_gnt;
    end

    uncached_wbuf #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wb_push),
        .push_entry (wb_in),
        .pop        (wb_pop),
        .head       (wb_head),
        .full       (wb_full),
        .empty      (wb_empty)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rddata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RD_WAIT && mem_rvalid)
                rddata_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;

        case (state_q)
            IDLE: begin
                if (wr_pres) begin
`ifdef UNCACHED_WBUF_EN
                    stall_c = ~wb_push;
`else
                    stall_c = 1'b1;
                    state_d = WR_REQ;
`endif
                end else if (rd_pres) begin
                    stall_c = 1'b1;
`ifdef UNCACHED_WBUF_EN
                    state_d = wb_empty ? RD_REQ : DRAIN;
`else
                    state_d = RD_REQ;
`endif
                end
            end
            RD_REQ: begin
                stall_c  = 1'b1;
                mem_req  = 1'b1;
                mem_addr = dbus_address;
                if (mem_gnt)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                stall_c = 1'b1;
                if (mem_rvalid)
                    state_d = RD_DONE;
            end
            // The held read is complete here; IDLE next cycle will not see
            // it as a new request because the CPU advances on stall=0.
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_REQ: begin
                stall_c   = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dbus_address;
                mem_wdata = dbus_wrdata;
                mem_be    = dbus_byteenable;
                if (mem_gnt)
                    state_d = WR_DONE;
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall_c = 1'b1;
`ifdef UNCACHED_WBUF_EN
                if (wb_empty)
                    state_d = RD_REQ;
`else
                state_d = RD_REQ;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UNCACHED_WBUF_EN
        if (wb_issue) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wb_head.addr;
            mem_wdata = wb_head.data;
            mem_be    = wb_head.be;
        end
`endif
    end

    // While reset is held a presented request must not show as a stall.
    assign dbus_stall  = stall_c & rst_n;
    assign dbus_rddata = rddata_q;

endmodule

// File: tb/tb_dbus_uncached_responder.sv
`timescale 1ns/1ps
module tb_dbus_uncached_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbus_read, dbus_write;
    logic [31:0] dbus_address, dbus_wrdata;
    logic [3:0]  dbus_byteenable;
    logic        dbus_stall;
    logic [31:0] dbus_rddata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dbus_uncached_responder #(.WBUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_address(dbus_address), .dbus_wrdata(dbus_wrdata),
        .dbus_byteenable(dbus_byteenable),
        .dbus_stall(dbus_stall), .dbus_rddata(dbus_rddata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents before any store: a fixed pattern per address.
    function automatic logic [31:0] deflt(input logic [31:0] a);
        if (a == 32'h1FD0_F000) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference: memory as the CPU sees it in program order.
    logic [31:0] ref_m [logic [31:0]];
    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_m.exists(a) ? ref_m[a] : deflt(a);
    endfunction

    // ---------------- memory responder ----------------
    typedef struct packed { logic we; logic [31:0] addr; } mev_t;
    mev_t        mlog [$];
    logic [31:0] mem_m [logic [31:0]];
    bit          gnt_block = 0, gnt_rand = 0, stray_rv = 0;
    int          gnt_delay = 0, rv_lat_cfg = 2;
    int          n_mem_req = 0, proto_err = 0;

    initial begin
        bit          prev_req, rd_pend;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata, rd_addr;
        logic [3:0]  prev_be;
        int          req_age, rv_cnt;
        prev_req = 0; rd_pend = 0; req_age = 0; rv_cnt = 0;
        prev_we = 0; prev_addr = 0; prev_wdata = 0; prev_be = 0; rd_addr = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_gnt = 0; mem_rvalid = 0;
                rd_pend = 0; prev_req = 0; req_age = 0;
                continue;
            end
            if (mem_rvalid) rd_pend = 0;
            if (mem_gnt) begin
                mlog.push_back('{prev_we, prev_addr});
                if (prev_we)
                    mem_m[prev_addr] = merge(mem_m.exists(prev_addr) ? mem_m[prev_addr]
                                             : deflt(prev_addr), prev_wdata, prev_be);
                else begin
                    rd_pend = 1; rd_addr = prev_addr;
                    rv_cnt = (rv_lat_cfg != 0) ? rv_lat_cfg : int'($urandom_range(1, 4));
                end
                prev_req = 0; req_age = 0;
            end
            mem_gnt = 0; mem_rvalid = 0;
            if (stray_rv) begin
                mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
            end else if (rd_pend) begin
                if (rv_cnt <= 1) begin
                    mem_rvalid = 1;
                    mem_rdata = mem_m.exists(rd_addr) ? mem_m[rd_addr] : deflt(rd_addr);
                end else rv_cnt--;
            end
            if (prev_req && !mem_req) proto_err++;
            if (mem_req) begin
                if (rd_pend) proto_err++;
                if (prev_req && (mem_addr !== prev_addr || mem_we !== prev_we ||
                                 mem_be !== prev_be || mem_wdata !== prev_wdata))
                    proto_err++;
                if (!prev_req) n_mem_req++;
                prev_req = 1; prev_we = mem_we; prev_addr = mem_addr;
                prev_wdata = mem_wdata; prev_be = mem_be;
                if (!gnt_block)
                    mem_gnt = gnt_rand ? ($urandom_range(0, 2) == 0) : (req_age >= gnt_delay);
                req_age++;
            end else begin
                prev_req = 0; req_age = 0;
            end
        end
    end

    // ---------------- CPU side ----------------
    task automatic sample(); @(negedge clk); #2; endtask
    task automatic next();   @(posedge clk); #1; endtask

    task automatic cpu_read(input logic [31:0] a, input string tag);
        bit ok;
        logic [31:0] d;
        dbus_read = 1; dbus_write = 0; dbus_address = a;
        ok = 0; d = 'x;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (!dbus_stall) begin ok = 1; d = dbus_rddata; break; end
            next();
        end
        chk({tag, "_done"}, 32'(ok), 1);
        if (ok) chk(tag, d, ref_get(a));
        next();
        dbus_read = 0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input bit with_rd);
        bit ok;
        dbus_write = 1; dbus_read = with_rd;
        dbus_address = a; dbus_wrdata = d; dbus_byteenable = be;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (!dbus_stall) begin ok = 1; break; end
            next();
        end
        chk("wr_done", 32'(ok), 1);
        if (ok) ref_m[a] = merge(ref_get(a), d, be);
        next();
        dbus_write = 0; dbus_read = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int n0, base;
        logic [31:0] a, d;
        rst_n = 0; dbus_read = 1; dbus_write = 0;
        dbus_address = 0; dbus_wrdata = 0; dbus_byteenable = 0;

        // reset state, with a read held so the stall gating is visible
        next(); sample();
        chk("rst_stall", 32'(dbus_stall), 0);
        chk("rst_rddata", dbus_rddata, 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        dbus_read = 0;
        next(); rst_n = 1; next();

        // single read: gnt in cycle 1, rvalid in cycle 3
        gnt_delay = 0; rv_lat_cfg = 2;
        n0 = n_mem_req;
        dbus_address = 32'h1FD0_F000; dbus_read = 1;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk($sformatf("r031_stall_c%0d", c), 32'(dbus_stall), 32'(c < 4));
            if (c == 4) chk("r031_rddata", dbus_rddata, 32'hDEAD_BEEF);
            next();
        end
        dbus_read = 0;
        chk("r031_one_req", 32'(n_mem_req - n0), 1);

        // reset during RD_WAIT, then a stray response
        rv_lat_cfg = 10;
        dbus_address = 32'h0000_2000; dbus_read = 1;
        sample(); chk("r035_c0_stall", 32'(dbus_stall), 1); next();
        sample(); next();
        sample(); chk("r035_wait_stall", 32'(dbus_stall), 1);
        next(); rst_n = 0; #1;
        chk("r035_rst_stall", 32'(dbus_stall), 0);
        chk("r035_rst_rddata", dbus_rddata, 0);
        chk("r035_rst_mem", {mem_req, mem_we, mem_be, mem_addr[25:0]}, 0);
        chk("r035_rst_wdata", mem_wdata, 0);
        dbus_read = 0;
        next(); rst_n = 1; stray_rv = 1;
        sample(); stray_rv = 0;
        chk("r035_stray_stall", 32'(dbus_stall), 0);
        next(); sample();
        chk("r035_after_rddata", dbus_rddata, 0);
        chk("r035_after_req", 32'(mem_req), 0);
        chk("r035_after_stall", 32'(dbus_stall), 0);
        next();
        rv_lat_cfg = 0;
        cpu_read(32'h1FD0_F000, "r035_reread");

`ifdef UNCACHED_WBUF_EN
        // five back-to-back stores with memory refusing grants
        gnt_block = 1; gnt_delay = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h300 + 32'(4 * i); d = 32'hA000_0000 + 32'(i);
            dbus_write = 1; dbus_address = a; dbus_wrdata = d; dbus_byteenable = 4'hF;
            sample();
            chk($sformatf("r032_nostall_%0d", i), 32'(dbus_stall), 0);
            if (!dbus_stall) ref_m[a] = d;
            next();
        end
        dbus_address = 32'h310; dbus_wrdata = 32'hA000_0004;
        sample(); chk("r032_full_stall0", 32'(dbus_stall), 1); next();
        sample(); chk("r032_full_stall1", 32'(dbus_stall), 1);
        gnt_block = 0;
        next(); sample();
        chk("r032_push_on_gnt", 32'(dbus_stall), 0);
        if (!dbus_stall) ref_m[32'h310] = 32'hA000_0004;
        next(); dbus_write = 0;
        repeat (12) next();

        // store then load to the same address: the store must reach memory first
        gnt_block = 1;
        base = mlog.size();
        cpu_write(32'h100, 32'h11, 4'hF, 0);
        gnt_block = 0;
        cpu_read(32'h100, "r033_rd");
        chk("r033_log_n", 32'(mlog.size() - base), 2);
        if (mlog.size() >= base + 2) begin
            chk("r033_first", {mlog[base].we, mlog[base].addr[30:0]}, {1'b1, 31'h100});
            chk("r033_second", {mlog[base+1].we, mlog[base+1].addr[30:0]}, {1'b0, 31'h100});
        end
`else
        // blocking store with partial byte enables, grant one cycle late
        gnt_delay = 1;
        dbus_write = 1; dbus_address = 32'h200; dbus_wrdata = 32'hCAFE_F00D;
        dbus_byteenable = 4'b0011;
        sample();
        chk("r034_c0_stall", 32'(dbus_stall), 1);
        chk("r034_c0_req", 32'(mem_req), 0);
        next(); sample();
        chk("r034_c1_req", 32'(mem_req), 1);
        chk("r034_c1_we", 32'(mem_we), 1);
        chk("r034_c1_be", 32'(mem_be), 32'b0011);
        chk("r034_c1_addr", mem_addr, 32'h200);
        chk("r034_c1_wdata", mem_wdata, 32'hCAFE_F00D);
        next(); sample();
        chk("r034_gnt_stall", 32'(dbus_stall), 1);
        next(); sample();
        chk("r034_done_stall", 32'(dbus_stall), 0);
        if (!dbus_stall) ref_m[32'h200] = merge(ref_get(32'h200), 32'hCAFE_F00D, 4'b0011);
        next(); dbus_write = 0;
        gnt_delay = 0;
        cpu_read(32'h200, "r034_rdback");
`endif

        // random mix of loads, stores and load+store against the reference
        gnt_rand = 1; rv_lat_cfg = 0;
        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            d = $urandom;
            if (op <= 1) cpu_read(a, "rnd_rd");
            else cpu_write(a, d, 4'($urandom_range(1, 15)), op == 4);
            repeat ($urandom_range(0, 2)) next();
        end
        chk("mem_protocol", 32'(proto_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
